// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the cache/memory control path.
//   word_t      : 32-bit data/address word
//   ramstate_t  : RAM handshake state reported by the memory
//                 (FREE=0, BUSY=1, ACCESS=2, ERROR=3)
// ----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/cache_mem_timer.sv
// ----------------------------------------------------------------------------
// cache_mem_timer
// Per-transaction watchdog for the cache/memory arbiter.
// Counts grant cycles that ended without a RAM access.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear_i      : hold the count at zero (asserted while not granted)
//   enable_i     : a grant cycle without ACCESS is in progress
//   expired_o    : this cycle is the one that brings the count to TIMEOUT-1
// ----------------------------------------------------------------------------
module cache_mem_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    // The abort fires at the edge where the count would reach TIMEOUT-1,
    // so the compare is against the value one below that.
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 2);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && !clear_i && (count_q == LIMIT);

endmodule

// File: rtl/cache_mem_arbiter.sv
// ----------------------------------------------------------------------------
// cache_mem_arbiter
// Responder side of the cache-control protocol. Serves one dcache and one
// icache word transaction at a time against a single-ported RAM, alternating
// grants when both caches are waiting, with a per-transaction timeout.
// Completion is a single-cycle low pulse on the selected wait line.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   dREN/dWEN/daddr/dstore -> dwait/dload   dcache side
//   iREN/iaddr             -> iwait/iload   icache side
//   ramREN/ramWEN/ramaddr/ramstore, ramload, ramstate   RAM side
//   memerr              sticky error flag (timeout or RAM ERROR)
//   dbg_state_o         current FSM state (debug observation)
//   dcount/icount       completed-transaction counters
//                       (only when CACHE_MEM_ARBITER_STATS_EN is defined)
//
// Handshake: a grant holds while its request is asserted; the transaction
// completes in the first grant cycle with ramstate==ACCESS, where the wait
// line is low for that cycle only and load data is valid alongside it.
// ----------------------------------------------------------------------------
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr,
    output logic [1:0]  dbg_state_o
`ifdef CACHE_MEM_ARBITER_STATS_EN
    ,
    output logic [31:0] dcount,
    output logic [31:0] icount
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DGRANT = 2'd1,
        S_IGRANT = 2'd2,
        S_ABORT  = 2'd3
    } state_t;

    state_t    state_q, state_d;
    logic      last_d_q;     // last completed grant went to the dcache
    logic      abort_d_q;    // aborting transaction belonged to the dcache
    logic      abort_wr_q;   // aborting transaction was a write
    logic      memerr_q;
    ramstate_t rs;
    logic      d_req, d_done, i_done, in_grant, expired;

    assign rs       = ramstate_t'(ramstate);
    assign d_req    = dREN | dWEN;
    assign in_grant = (state_q == S_DGRANT) || (state_q == S_IGRANT);
    assign d_done   = (state_q == S_DGRANT) && d_req && (rs == ACCESS);
    assign i_done   = (state_q == S_IGRANT) && iREN  && (rs == ACCESS);

    cache_mem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clear_i   (!in_grant),
        .enable_i  (in_grant && (rs != ACCESS)),
        .expired_o (expired)
    );

    // Next state. A dropped request outranks everything; ACCESS outranks
    // a timer expiry landing in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (d_req && (!iREN || !last_d_q)) begin
                    state_d = S_DGRANT;
                end else if (iREN) begin
                    state_d = S_IGRANT;
                end
            end
            S_DGRANT: begin
                if (!d_req || rs == ACCESS) begin
                    state_d = S_IDLE;
                end else if (rs == ERROR || expired) begin
                    state_d = S_ABORT;
                end
            end
            S_IGRANT: begin
                if (!iREN || rs == ACCESS) begin
                    state_d = S_IDLE;
                end else if (rs == ERROR || expired) begin
                    state_d = S_ABORT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            last_d_q   <= 1'b0;
            abort_d_q  <= 1'b0;
            abort_wr_q <= 1'b0;
            memerr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (d_done) begin
                last_d_q <= 1'b1;
            end else if (i_done) begin
                last_d_q <= 1'b0;
            end
            // Capture who is being aborted and how, since the request
            // lines are no longer consulted in the ABORT cycle.
            if (in_grant && state_d == S_ABORT) begin
                abort_d_q  <= (state_q == S_DGRANT);
                abort_wr_q <= (state_q == S_DGRANT) && dWEN;
            end
            if (state_q == S_ABORT) begin
                memerr_q <= 1'b1;
            end
        end
    end

`ifdef CACHE_MEM_ARBITER_STATS_EN
    logic [31:0] dcount_q, icount_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dcount_q <= '0;
            icount_q <= '0;
        end else begin
            if (d_done) dcount_q <= dcount_q + 32'd1;
            if (i_done) icount_q <= icount_q + 32'd1;
        end
    end

    assign dcount = dcount_q;
    assign icount = icount_q;
`endif

    // Outputs follow state and live inputs combinationally, so address and
    // data changes during a grant reach the RAM in the same cycle.
    always_comb begin
        dwait    = 1'b1;
        iwait    = 1'b1;
        dload    = '0;
        iload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            S_DGRANT: begin
                if (d_req) begin
                    ramaddr = daddr;
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (rs == ACCESS) begin
                        dwait = 1'b0;
                        dload = dWEN ? '0 : ramload;
                    end
                end
            end
            S_IGRANT: begin
                if (iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (rs == ACCESS) begin
                        iwait = 1'b0;
                        iload = ramload;
                    end
                end
            end
            S_ABORT: begin
                if (abort_d_q) begin
                    dwait = 1'b0;
                    dload = abort_wr_q ? '0 : ERR_WORD;
                end else begin
                    iwait = 1'b0;
                    iload = ERR_WORD;
                end
            end
            default: ;
        endcase
    end

    assign memerr      = memerr_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Responder end of the cache-control protocol: serves dcache (dREN/dWEN/daddr/dstore, returns dwait/dload) and icache (iREN/iaddr, returns iwait/iload) against a single-ported RAM with a ramstate handshake.
- Arbitrates between the two caches, one word per transaction.
- Enforces a per-transaction timeout.
- Signals completion by pulling the selected wait line low for exactly one cycle.

Parameters:
- TIMEOUT, 64: max cycles in a grant state without ramstate==ACCESS before the transaction is aborted; legal range 2..255.
- ERR_WORD, 32'hBAD1BAD1: load value returned on an aborted or errored read.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  low for one cycle = dcache transaction complete.
- dload  out  32  dcache read data, valid only while dwait==0.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  low for one cycle = icache transaction complete.
- iload  out  32  icache read data, valid only while iwait==0.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- memerr  out  1  sticky; set on any timeout or ERROR.

Behaviour:
- Reset (RST=1, any time, including mid-transaction):
  - FSM→IDLE, timer=0, memerr=0, last_grant=I.
  - Outputs: dwait=1, iwait=1, dload=0, iload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - No completion pulse is issued for a transaction cut off by reset.
- FSM states: IDLE, DGRANT, IGRANT, ABORT. State and timer are registered; all outputs are combinational from state plus inputs.
- IDLE:
  - No RAM strobes; both waits high.
  - Arbitration, evaluated at each rising edge:
    - Only d request (dREN|dWEN) → DGRANT.
    - Only iREN → IGRANT.
    - Both pending → DGRANT, unless last_grant==D, then IGRANT (alternation prevents starvation).
- DGRANT:
  - Drive ramaddr=daddr.
  - If dWEN: ramWEN=1, ramstore=dstore. Write wins when dREN and dWEN are both high.
  - Else ramREN=1.
  - ramstate==ACCESS: dwait=0 and dload=ramload (0 on writes) that cycle; next state IDLE; last_grant=D.
- IGRANT: ramREN=1, ramaddr=iaddr. On ACCESS: iwait=0, iload=ramload; next state IDLE; last_grant=I.
- Grants are not preemptive. A new dcache request during IGRANT waits.
- Request dropped while granted (dREN=dWEN=0 in DGRANT, or iREN=0 in IGRANT): next state IDLE, no wait pulse, strobes deassert the same cycle.
- Address/data changing mid-grant is forwarded combinationally; the completed word is whatever is presented in the ACCESS cycle.
- Latency: request seen in IDLE at edge N → strobes from cycle N+1 → completion in the first cycle with ramstate==ACCESS. Minimum 1 cycle after the request edge.
- Back-to-back: at least one IDLE cycle (wait high) between consecutive completions to the same cache.
- Timer:
  - Cleared on entry to a grant state; increments each grant cycle without ACCESS.
  - Reaching TIMEOUT-1, or ramstate==ERROR → ABORT.
- ABORT (one cycle):
  - Strobes low.
  - The granted cache's wait=0, its load=ERR_WORD for reads (0 for writes).
  - memerr←1; next state IDLE.
- ACCESS and timer expiry in the same cycle: ACCESS wins.
- ramstate==ACCESS in IDLE is ignored.

Optional Feature:
- Macro: CACHE_MEM_ARBITER_STATS_EN.
- When defined:
  - Adds outputs dcount[31:0] and icount[31:0].
  - Each increments on every completed (non-aborted) transaction for its cache and wraps at 2^32.
  - Both reset to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- cpu_types_pkg: word_t, ramstate_t (FREE/BUSY/ACCESS/ERROR).
- FSM state enum is local to the module.
- One sub-module: cache_mem_timer (clear, enable, TIMEOUT parameter, expired output), instantiated once.

Test Plan:
- dREN=1, daddr=0x40, RAM returns ACCESS after 3 BUSY cycles with ramload=0x1234 → ramREN high for 4 cycles, dwait=0 for exactly one cycle with dload=0x1234, then IDLE.
- dREN and iREN asserted together from IDLE, both held → grant order D, I, D, I; each completion a single wait-low pulse; last_grant alternates.
- dWEN=1 and dREN=1, dstore=0xCAFEF00D → ramWEN=1, ramREN=0, ramstore=0xCAFEF00D; dwait pulse on ACCESS.
- ramstate held BUSY, TIMEOUT=8, iREN=1 → ABORT after 7 grant cycles; iwait=0 with iload=0xBAD1BAD1; memerr=1 stays set.
- RST asserted in DGRANT mid-wait → outputs return to reset values immediately, no dwait pulse; after release, a fresh request completes normally.
- With CACHE_MEM_ARBITER_STATS_EN: 3 d completions, 2 i completions, 1 abort → dcount=3, icount=2.
